// File: rtl/avalon_tick_timer_pkg.sv
// Shared constants for the Avalon tick timer: register map, CTRL/STATUS bit positions, bus timing.
package avalon_tick_timer_pkg;
    localparam int REG_CTRL     = 0;
    localparam int REG_PRESCALE = 1;
    localparam int REG_COUNT    = 2;
    localparam int REG_LIMIT    = 3;
    localparam int REG_ALARM    = 4;
    localparam int REG_STATUS   = 5;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_CLR     = 3;

    localparam int STATUS_WRAP  = 0;
    localparam int STATUS_ALARM = 1;

    localparam int READ_LATENCY = 1;
endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every `period` enabled cycles; period 0 or 1 ticks every cycle.
module tick_prescaler #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] period,
    output logic                  tick
);
    logic [DATA_WIDTH-1:0] pcnt;
    logic                  at_end;

    assign at_end = (period <= DATA_WIDTH'(1)) || (pcnt == period - DATA_WIDTH'(1));
    assign tick   = en && !reset && at_end;

    always_ff @(posedge clk) begin
        if (reset || clr)
            pcnt <= '0;
        else if (en)
            pcnt <= at_end ? '0 : pcnt + DATA_WIDTH'(1);
    end
endmodule

// File: rtl/avalon_tick_timer.sv
// Avalon-MM tick timer: register file, modulo counter with alarm compare, sticky W1C flags, level irq.
module avalon_tick_timer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int SUBSAMP    = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic                  read,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  irq
);
    import avalon_tick_timer_pkg::*;

    logic [CTRL_CLR-1:0]   ctrl;
    logic [DATA_WIDTH-1:0] prescale, count, limit, alarm;
    logic [1:0]            status;

    logic wr_en, rd_en;
    logic wr_ctrl, wr_prescale, wr_count, wr_limit, wr_alarm, wr_status;
    logic clr_req, tick, hw_tick, at_end, wrap, alarm_hit;
    logic [DATA_WIDTH-1:0] count_next, rd_mux;
    logic [1:0]            w1c;

    assign wr_en       = chipselect && write;
    assign rd_en       = chipselect && read;
    assign wr_ctrl     = wr_en && (address == ADDR_WIDTH'(REG_CTRL));
    assign wr_prescale = wr_en && (address == ADDR_WIDTH'(REG_PRESCALE));
    assign wr_count    = wr_en && (address == ADDR_WIDTH'(REG_COUNT));
    assign wr_limit    = wr_en && (address == ADDR_WIDTH'(REG_LIMIT));
    assign wr_alarm    = wr_en && (address == ADDR_WIDTH'(REG_ALARM));
    assign wr_status   = wr_en && (address == ADDR_WIDTH'(REG_STATUS));
    assign clr_req     = wr_ctrl && writedata[CTRL_CLR];

    tick_prescaler #(.DATA_WIDTH(DATA_WIDTH)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (ctrl[CTRL_EN]),
        .clr    (wr_prescale || clr_req),
        .period (prescale),
        .tick   (tick)
    );

    // A software write to COUNT (or CLR) in the tick cycle overrides the hardware step and its flags.
    always_comb begin
        at_end     = ((limit != '0) && (count == limit)) || (count == '1);
        count_next = at_end ? '0 : count + DATA_WIDTH'(1);
        hw_tick    = tick && !wr_count && !clr_req;
        wrap       = hw_tick && at_end;
        alarm_hit  = hw_tick && (count_next == alarm);
        w1c        = wr_status ? writedata[1:0] : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            prescale <= DATA_WIDTH'(SUBSAMP);
            count    <= '0;
            limit    <= '0;
            alarm    <= '0;
            status   <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl <= writedata[CTRL_CLR-1:0];
            else if (wrap && ctrl[CTRL_ONESHOT])
                ctrl[CTRL_EN] <= 1'b0;

            if (wr_prescale) prescale <= writedata;
            if (wr_limit)    limit    <= writedata;
            if (wr_alarm)    alarm    <= writedata;

            if (clr_req)
                count <= '0;
            else if (wr_count)
                count <= writedata;
            else if (hw_tick)
                count <= count_next;

            // Hardware set dominates a same-cycle write-1-to-clear.
            status[STATUS_WRAP]  <= (status[STATUS_WRAP]  && !w1c[STATUS_WRAP])  || wrap;
            status[STATUS_ALARM] <= (status[STATUS_ALARM] && !w1c[STATUS_ALARM]) || alarm_hit;

            irq <= ctrl[CTRL_IRQ_EN] && (|status);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_WIDTH'(REG_CTRL):     rd_mux = DATA_WIDTH'(ctrl);
            ADDR_WIDTH'(REG_PRESCALE): rd_mux = prescale;
            ADDR_WIDTH'(REG_COUNT):    rd_mux = count;
            ADDR_WIDTH'(REG_LIMIT):    rd_mux = limit;
            ADDR_WIDTH'(REG_ALARM):    rd_mux = alarm;
            ADDR_WIDTH'(REG_STATUS):   rd_mux = DATA_WIDTH'(status);
            default:                   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else if (rd_en)
            readdata <= rd_mux;
    end
endmodule

// File: tb/tb_avalon_tick_timer.sv
// Bench for avalon_tick_timer: register table, directed timing sequences, random traffic vs a cycle model.
module tb_avalon_tick_timer;
    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] writedata = '0;
    logic [DW-1:0] readdata;
    logic          irq;

    int checks = 0;
    int errors = 0;

    avalon_tick_timer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SUBSAMP(50000)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: register-level behaviour with plain integers, updated once per clock edge.
    bit          m_valid = 1'b0;
    bit          m_en, m_ie, m_os, m_wf, m_af, m_irq;
    int unsigned m_ps, m_cnt, m_lim, m_alm, m_pc;
    logic [31:0] m_rd;

    task automatic model_step();
        bit          wr, rd, tick, clr, wrap, hit;
        int unsigned nxt;
        int          a;
        wr = chipselect && write;
        rd = chipselect && read;
        a  = int'(address);
        if (reset) begin
            {m_en, m_ie, m_os, m_wf, m_af, m_irq} = '0;
            m_ps = 50000; m_cnt = 0; m_lim = 0; m_alm = 0; m_pc = 0; m_rd = '0;
            m_valid = 1'b1;
            return;
        end
        if (rd) begin
            case (a)
                0: m_rd = {29'b0, m_os, m_ie, m_en};
                1: m_rd = m_ps;
                2: m_rd = m_cnt;
                3: m_rd = m_lim;
                4: m_rd = m_alm;
                5: m_rd = {30'b0, m_af, m_wf};
                default: m_rd = '0;
            endcase
        end
        tick  = m_en && (m_ps <= 1 || m_pc == m_ps - 1);
        m_irq = m_ie && (m_wf || m_af);
        clr   = wr && a == 0 && writedata[3];
        if (clr || (wr && a == 1)) m_pc = 0;
        else if (m_en) m_pc = tick ? 0 : m_pc + 1;
        wrap = 1'b0;
        hit  = 1'b0;
        if (clr) m_cnt = 0;
        else if (wr && a == 2) m_cnt = writedata;
        else if (tick) begin
            if ((m_lim != 0 && m_cnt == m_lim) || m_cnt == 32'hFFFF_FFFF) begin
                nxt = 0; wrap = 1'b1;
            end else nxt = m_cnt + 1;
            hit   = (nxt == m_alm);
            m_cnt = nxt;
        end
        if (wr && a == 5) begin
            if (writedata[0]) m_wf = 1'b0;
            if (writedata[1]) m_af = 1'b0;
        end
        if (wrap) m_wf = 1'b1;
        if (hit)  m_af = 1'b1;
        if (wr && a == 0) {m_os, m_ie, m_en} = writedata[2:0];
        else if (wrap && m_os) m_en = 1'b0;
        if (wr && a == 1) m_ps  = writedata;
        if (wr && a == 3) m_lim = writedata;
        if (wr && a == 4) m_alm = writedata;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("model_readdata", readdata, m_rd);
            check("model_irq", irq, m_irq);
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; read = 1'b0; address = AW'(a); writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = AW'(a);
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    typedef struct {
        bit          we;
        int          addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input bit we, input int a, input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.we = we; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] v;
        logic [31:0] cnt_seq[8];
        // first 8 entries are the reset-value reads
        add(0, 0, 0, 0);  add(0, 1, 0, 50000); add(0, 2, 0, 0); add(0, 3, 0, 0);
        add(0, 4, 0, 0);  add(0, 5, 0, 0);     add(0, 6, 0, 0); add(0, 7, 0, 0);
        add(1, 3, 7, 0);  add(0, 3, 0, 7);     add(1, 4, 9, 0); add(0, 4, 0, 9);
        add(1, 6, 255, 0); add(0, 6, 0, 0);    add(1, 0, 14, 0); add(0, 0, 0, 6);
        add(1, 0, 0, 0);  add(1, 2, 5, 0);     add(0, 2, 0, 5); add(1, 1, 4, 0);
        add(0, 1, 0, 4);  add(1, 3, 0, 0);     add(1, 4, 0, 0); add(1, 2, 0, 0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_irq", irq, 0);
        check("reset_readdata", readdata, 0);

        foreach (vecs[i]) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
            else begin
                rd(vecs[i].addr, v);
                check($sformatf("vec%0d", i), v, vecs[i].exp);
            end
        end

        // PRESCALE=4, LIMIT=3: COUNT steps every 4 cycles and wraps after 3
        wr(1, 4); wr(3, 3); wr(0, 1);
        chipselect = 1'b1; read = 1'b1; address = AW'(2);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check($sformatf("count_div4_%0d", i), readdata, (i / 4) % 4);
        end
        chipselect = 1'b0; read = 1'b0;
        wr(0, 0);
        rd(5, v); check("status_after_wrap", v, 3);
        wr(5, 3);
        rd(5, v); check("status_w1c", v, 0);

        // alarm at 2 with irq one cycle after the flag
        wr(3, 0); wr(1, 1); wr(4, 2); wr(2, 0); wr(0, 3);
        @(negedge clk); check("alarm_irq_c1", irq, 0);
        @(negedge clk); check("alarm_irq_c2", irq, 0);
        @(negedge clk); check("alarm_irq_c3", irq, 1);
        wr(0, 2);
        rd(5, v); check("alarm_status", v, 2);
        wr(5, 2);
        check("irq_after_w1c", irq, 1);
        @(negedge clk); check("irq_dropped", irq, 0);

        // oneshot: 0,1,2,0 then stopped
        wr(0, 0); wr(2, 0); wr(5, 3); wr(3, 2); wr(0, 5);
        cnt_seq = '{0, 1, 2, 0, 0, 0, 0, 0};
        chipselect = 1'b1; read = 1'b1; address = AW'(2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("oneshot_%0d", i), readdata, cnt_seq[i]);
        end
        chipselect = 1'b0; read = 1'b0;
        rd(0, v); check("oneshot_ctrl", v, 4);
        rd(5, v); check("oneshot_status", v, 3);
        wr(5, 3);

        // COUNT write in a tick cycle: written value wins, no alarm even though it equals ALARM
        wr(3, 0); wr(4, 9); wr(0, 1); wr(2, 9); wr(0, 0);
        rd(2, v); check("sw_count_wins", v, 10);
        rd(5, v); check("sw_count_noflag", v, 0);

        // W1C of ALARM_F in the same cycle the tick sets it
        wr(2, 20); wr(4, 21); wr(0, 1); wr(5, 2); wr(0, 0);
        rd(5, v); check("w1c_vs_set", v, 2);
        wr(5, 3);

        // reset while COUNT=5 with flag and irq active
        wr(4, 5); wr(2, 4); wr(0, 3); wr(0, 2);
        rd(2, v); check("pre_reset_count", v, 5);
        check("pre_reset_irq", irq, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_irq", irq, 0);
        check("midreset_readdata", readdata, 0);
        for (int i = 0; i < 8; i++) begin
            rd(vecs[i].addr, v);
            check($sformatf("midreset_reg%0d", i), v, vecs[i].exp);
        end

        // random traffic checked cycle-by-cycle against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r          = int'($urandom_range(0, 199));
            reset      = (r == 0);
            chipselect = ($urandom_range(0, 3) != 0);
            write      = ($urandom_range(0, 2) == 0);
            read       = ($urandom_range(0, 1) == 1);
            address    = AW'($urandom_range(0, 7));
            case (int'(address))
                0:       writedata = $urandom_range(0, 15);
                1:       writedata = $urandom_range(0, 4);
                2:       writedata = (r < 6) ? 32'hFFFF_FFFD : $urandom_range(0, 12);
                3, 4:    writedata = $urandom_range(0, 10);
                default: writedata = $urandom;
            endcase
            @(negedge clk);
        end
        reset = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
